// File: rtl/pp_pkg.sv
// ---------------------------------------------------------------------------
// pp_pkg
// Shared definitions for the iterative partial-product reduction sequencer:
// default datapath width and row-buffer depth, the count-width helper, and
// the sequencer state encoding.
//
// Optional feature macro used by the top level: PP_REDUCE_CHECK_EN
// ---------------------------------------------------------------------------
package pp_pkg;

    localparam int PP_WIDTH = 128;   // bit width of every partial-product row
    localparam int PP_ROWS  = 16;    // maximum rows per operation

    // Width of a counter that must hold the values 0..rows inclusive.
    function automatic int cnt_width(input int rows);
        return $clog2(rows + 1);
    endfunction

    localparam int PP_CNT_W = cnt_width(PP_ROWS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        REDUCE,
        DONE
    } pp_state_e;

endpackage

// File: rtl/pp_compressor.sv
// ---------------------------------------------------------------------------
// pp_compressor
// One WIDTH-bit row of 4:2 compressors built from two chained full adders
// per bit. Purely combinational.
//
// Ports:
//   a, b, c, d : input rows to compress
//   cin        : horizontal carry-in row (the caller feeds co << 1)
//   s          : sum row
//   k          : carry row (weight 2, not yet shifted)
//   co         : horizontal carry-out row (weight 2, not yet shifted)
//
// co depends only on a, b, c, so feeding it back into cin through a shift
// forms no combinational loop.
// ---------------------------------------------------------------------------
module pp_compressor
    import pp_pkg::*;
#(
    parameter int WIDTH = PP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] cin,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] co
);

    logic [WIDTH-1:0] ab_x;
    logic [WIDTH-1:0] abcd_x;

    assign ab_x   = a ^ b;
    assign abcd_x = ab_x ^ c ^ d;

    // First full adder (a, b, c): majority written as a mux on a^b.
    assign co = (ab_x & c) | (~ab_x & a);

    // Second full adder (a^b^c, d, cin).
    assign s  = abcd_x ^ cin;
    assign k  = (abcd_x & cin) | (~abcd_x & d);

endmodule

// File: rtl/pp_row_buffer.sv
// ---------------------------------------------------------------------------
// pp_row_buffer
// Register array holding the partial-product rows of one operation.
// Supports append at the tail, a compression step that pops 3 or 4 rows from
// the head, shifts the remainder down and appends the sum/carry pair, and a
// whole-buffer clear.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : zero every slot and the count
//   push_en    : append push_row at index count (caller guarantees room)
//   push_row   : row to append
//   step_en    : perform one compression step
//   step_four  : 1 = consume rows 0..3, 0 = consume rows 0..2
//   step_s     : sum row appended by the step
//   step_k     : carry row appended by the step (already shifted)
//   head_o     : rows 0..3, feeding the compressor and the output stage
//   count_o    : number of valid rows
//
// Invariant: every slot at or beyond count is zero, so shifted-in slots and
// absent rows always read as zero.
// ---------------------------------------------------------------------------
module pp_row_buffer
    import pp_pkg::*;
#(
    parameter  int WIDTH = PP_WIDTH,
    parameter  int ROWS  = PP_ROWS,
    localparam int CW    = cnt_width(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push_en,
    input  logic [WIDTH-1:0]      push_row,
    input  logic                  step_en,
    input  logic                  step_four,
    input  logic [WIDTH-1:0]      step_s,
    input  logic [WIDTH-1:0]      step_k,
    output logic [3:0][WIDTH-1:0] head_o,
    output logic [CW-1:0]         count_o
);

    logic [ROWS-1:0][WIDTH-1:0] rows_q, rows_d;
    logic [CW-1:0]              count_q, count_d;
    logic [ROWS-1:0][WIDTH-1:0] shifted;
    logic [CW-1:0]              pos;

    // NOTE: every signal written in an always_comb gets a default at the top
    // of the block; a path that leaves one unassigned infers a latch.
    always_comb begin
        rows_d  = rows_q;
        count_d = count_q;
        shifted = '0;

        // Remainder after dropping the consumed head rows.
        if (step_four) begin
            for (int j = 0; j < ROWS - 4; j++) shifted[j] = rows_q[j + 4];
        end else begin
            for (int j = 0; j < ROWS - 3; j++) shifted[j] = rows_q[j + 3];
        end
        pos = step_four ? (count_q - CW'(4)) : (count_q - CW'(3));

        if (clr) begin
            rows_d  = '0;
            count_d = '0;
        end else if (push_en) begin
            for (int j = 0; j < ROWS; j++) begin
                if (count_q == CW'(j)) rows_d[j] = push_row;
            end
            count_d = count_q + CW'(1);
        end else if (step_en) begin
            rows_d = shifted;
            for (int j = 0; j < ROWS; j++) begin
                if (pos == CW'(j))          rows_d[j] = step_s;
                if (pos + CW'(1) == CW'(j)) rows_d[j] = step_k;
            end
            count_d = pos + CW'(2);
        end
    end

    // NOTE: non-blocking assignments in clocked blocks, so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this array is reset on purpose: the zero-beyond-count
            // invariant is what makes missing rows read as zero.
            rows_q  <= '0;
            count_q <= '0;
        end else begin
            rows_q  <= rows_d;
            count_q <= count_d;
        end
    end

    assign head_o  = rows_q[3:0];
    assign count_o = count_q;

endmodule

// File: rtl/pp_reduce_seq.sv
// ---------------------------------------------------------------------------
// pp_reduce_seq
// Iterative partial-product reduction sequencer. Rows arrive serially into a
// row buffer; one shared 4:2 compressor row then folds 4 (or 3) rows into a
// sum/carry pair per cycle until at most two rows remain, and the pair is
// presented to the final carry-propagate adder.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : row input handshake
//   in_row, in_last       : partial-product row, final-row marker
//   out_valid/out_ready   : reduced pair handshake
//   out_sum, out_carry    : reduced pair (carry already shifted left by 1)
//   check_err             : sticky reference-sum mismatch flag
//
// Optional feature macro: PP_REDUCE_CHECK_EN
//   defined   : a shadow accumulator sums every accepted row and check_err
//               latches when out_sum + out_carry disagrees with it.
//   undefined : no accumulator, check_err is tied low.
//
// Timing: the output pair is registered one cycle after the buffer settles,
// so out_valid rises S+1 cycles after the last-row handshake (S = steps).
// ---------------------------------------------------------------------------
module pp_reduce_seq
    import pp_pkg::*;
#(
    parameter  int WIDTH = PP_WIDTH,
    parameter  int ROWS  = PP_ROWS,
    localparam int CW    = cnt_width(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_row,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_carry,
    output logic             check_err
);

    pp_state_e        state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic [WIDTH-1:0] out_carry_q, out_carry_d;

    logic                  accept;
    logic                  push_en;
    logic                  step_en;
    logic                  step_four;
    logic                  clr;
    logic                  load_out;
    logic [3:0][WIDTH-1:0] head;
    logic [CW-1:0]         count;

    logic [WIDTH-1:0] cmp_d;
    logic [WIDTH-1:0] cmp_cin;
    logic [WIDTH-1:0] cmp_s;
    logic [WIDTH-1:0] cmp_k;
    logic [WIDTH-1:0] cmp_co;
    logic             unused_msbs;

    // ---------------------------------------------------------------- datapath
    pp_row_buffer #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push_en   (push_en),
        .push_row  (in_row),
        .step_en   (step_en),
        .step_four (step_four),
        .step_s    (cmp_s),
        .step_k    ({cmp_k[WIDTH-2:0], 1'b0}),
        .head_o    (head),
        .count_o   (count)
    );

    // With only three rows left the fourth compressor input is zero.
    assign step_four = (count >= CW'(4));
    assign cmp_d     = step_four ? head[3] : '0;
    assign cmp_cin   = {cmp_co[WIDTH-2:0], 1'b0};

    pp_compressor #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a   (head[0]),
        .b   (head[1]),
        .c   (head[2]),
        .d   (cmp_d),
        .cin (cmp_cin),
        .s   (cmp_s),
        .k   (cmp_k),
        .co  (cmp_co)
    );

    // Carries shifted out of the top bit are discarded (modulo 2^WIDTH).
    assign unused_msbs = cmp_co[WIDTH-1] ^ cmp_k[WIDTH-1];

    // ---------------------------------------------------------------- control
    assign in_ready = !rst && ((state_q == IDLE) || (state_q == LOAD))
                      && (count < CW'(ROWS));
    assign accept   = in_valid && in_ready;
    assign load_out = (state_q == DONE) && !out_valid_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        push_en     = 1'b0;
        step_en     = 1'b0;
        clr         = 1'b0;

        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    push_en = 1'b1;
                    // Filling the last slot ends the operation even without in_last.
                    if (in_last || (count == CW'(ROWS - 1))) begin
                        state_d = (count <= CW'(1)) ? DONE : REDUCE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            REDUCE: begin
                step_en = 1'b1;
                // 4 rows -> 2 or 3 rows -> 2 both finish the reduction.
                if (count <= CW'(4)) state_d = DONE;
            end
            DONE: begin
                if (load_out) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = head[0];
                    out_carry_d = head[1];
                end else if (out_ready) begin
                    clr         = 1'b1;
                    out_valid_d = 1'b0;
                    out_sum_d   = '0;
                    out_carry_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;

    // ---------------------------------------------------------------- checker
`ifdef PP_REDUCE_CHECK_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             check_err_q, check_err_d;

    always_comb begin
        acc_d       = acc_q;
        check_err_d = check_err_q;
        if (clr) begin
            acc_d = '0;
        end else if (push_en) begin
            acc_d = acc_q + in_row;
        end
        // Compared when the pair is registered; the flag stays set until rst.
        if (load_out && ((head[0] + head[1]) != acc_q)) check_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            check_err_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            check_err_q <= check_err_d;
        end
    end

    assign check_err = check_err_q;
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_pp_reduce_seq.sv
// ---------------------------------------------------------------------------
// tb_pp_reduce_seq
// Directed scoreboard bench for pp_reduce_seq. The driver pushes the hand-
// computed expected pair and latency at each last-row handshake; a monitor
// pops and compares whenever the DUT hands a pair off.
// ---------------------------------------------------------------------------
module tb_pp_reduce_seq;

    localparam int W    = 128;
    localparam int ROWS = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_row;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic [W-1:0] out_carry;
    logic         check_err;

    pp_reduce_seq #(
        .WIDTH (W),
        .ROWS  (ROWS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .check_err (check_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] sum;
        logic [W-1:0] carry;
        bit           pair_only;  // compare only out_sum + out_carry against sum
        int           hs_cyc;
        int           lat;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] stim[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // ------------------------------------------------------------- monitor
    initial begin : monitor
        bit           seen;
        int           rise_cyc;
        logic [W-1:0] cap_s;
        logic [W-1:0] cap_c;
        exp_t         e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen     = 1'b1;
                    rise_cyc = cyc;
                    cap_s    = out_sum;
                    cap_c    = out_carry;
                end else begin
                    check("hold_sum", out_sum, cap_s);
                    check("hold_carry", out_carry, cap_c);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        if (e.pair_only) begin
                            check({e.name, "_pair_sum"}, out_sum + out_carry, e.sum);
                        end else begin
                            check({e.name, "_sum"}, out_sum, e.sum);
                            check({e.name, "_carry"}, out_carry, e.carry);
                        end
                        check({e.name, "_latency"}, W'(rise_cyc - e.hs_cyc), W'(e.lat));
                        check({e.name, "_check_err"}, W'(check_err), '0);
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------- driver
    task automatic send_row(input logic [W-1:0] row, input bit last, output int hs);
        int waited = 0;
        in_valid = 1'b1;
        in_row   = row;
        in_last  = last;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            fail_now("in_ready_timeout");
            hs = cyc;
        end else begin
            @(posedge clk);
            #1;
            hs = cyc;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_op(input bit use_last, output int hs);
        for (int i = 0; i < stim.size(); i++) begin
            send_row(stim[i], use_last && (i == stim.size() - 1), hs);
        end
    endtask

    task automatic expect_pair(input string name, input logic [W-1:0] s,
                               input logic [W-1:0] c, input bit pair_only,
                               input int hs, input int lat);
        exp_t e;
        e.name = name; e.sum = s; e.carry = c; e.pair_only = pair_only;
        e.hs_cyc = hs; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Bounded run time: a hang anywhere still ends the simulation.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- stimulus
    initial begin : main
        int           hs;
        logic [W-1:0] top_bit;
        top_bit   = '0;
        top_bit[W-1] = 1'b1;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_out_sum", out_sum, '0);
        check("rst_out_carry", out_carry, '0);
        check("rst_check_err", W'(check_err), '0);
        check("rst_in_ready", W'(in_ready), '0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", W'(in_ready), W'(1));

        // Four rows: one 4:2 step.
        stim = '{W'(1), W'(2), W'(3), W'(4)};
        send_op(1'b1, hs);
        expect_pair("four_rows", W'(2), W'(8), 1'b0, hs, 2);
        wait_drain();

        // Five rows: 4-row step to [5,2,8], then a 3-row step.
        stim = '{W'(1), W'(2), W'(3), W'(4), W'(5)};
        send_op(1'b1, hs);
        expect_pair("five_rows", W'(15), W'(0), 1'b0, hs, 3);
        wait_drain();

        // Single row passes straight through.
        stim = '{W'(16'hABCD)};
        send_op(1'b1, hs);
        expect_pair("one_row", W'(16'hABCD), W'(0), 1'b0, hs, 1);
        wait_drain();

        // Two rows pass straight through.
        stim = '{W'(16'h1234), W'(16'h5678)};
        send_op(1'b1, hs);
        expect_pair("two_rows", W'(16'h1234), W'(16'h5678), 1'b0, hs, 1);
        wait_drain();

        // Three rows: single 3-row step.
        stim = '{W'(1), W'(2), W'(3)};
        send_op(1'b1, hs);
        expect_pair("three_rows", W'(6), W'(0), 1'b0, hs, 2);
        wait_drain();

        // Four copies of 2^127: every carry falls off the top.
        stim = '{top_bit, top_bit, top_bit, top_bit};
        send_op(1'b1, hs);
        expect_pair("wrap_rows", W'(0), W'(0), 1'b0, hs, 2);
        wait_drain();

        // Sixteen rows of 2^127+1 with no in_last; downstream stalled.
        out_ready = 1'b0;
        stim.delete();
        for (int i = 0; i < ROWS; i++) stim.push_back(top_bit | W'(1));
        send_op(1'b0, hs);
        expect_pair("full_rows", W'(16), W'(0), 1'b1, hs, 8);
        // A 17th row is offered but must not be taken.
        in_valid = 1'b1;
        in_row   = W'(16'hDEAD);
        in_last  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            check("no_17th_row", W'(in_ready), '0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("stall_out_valid", W'(out_valid), W'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_out_valid", W'(out_valid), '0);
        check("post_hs_in_ready", W'(in_ready), W'(1));
        wait_drain();

        // Twelve rows, reset during REDUCE: nothing may come out.
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(W'(i + 1));
        send_op(1'b1, hs);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", W'(in_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", W'(out_valid), '0);
        check("mid_rst_out_sum", out_sum, '0);
        check("mid_rst_out_carry", out_carry, '0);
        check("mid_rst_check_err", W'(check_err), '0);
        #1;
        check("mid_rst_in_ready_idle", W'(in_ready), W'(1));
        repeat (12) @(posedge clk);
        #1;
        check("mid_rst_no_output", W'(out_valid), '0);

        // Fresh four-row op after the reset.
        stim = '{W'(16'h10), W'(16'h20), W'(16'h30), W'(16'h40)};
        send_op(1'b1, hs);
        expect_pair("after_rst", W'(16'h20), W'(16'h80), 1'b0, hs, 2);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
